eight_bit_adder_reg: RTL and testbench

Registered 8-bit unsigned adder. Sums two 8-bit operands through a ripple-carry chain of full-adder cells and captures the 8-bit sum and the carry-out in an output register. Used as a datapath arithmetic primitive wherever a one-cycle-latency add with an explicit carry-out is needed.

---
 rtl/eight_bit_adder_reg.sv | 103 ++++++++++
 tb/tb_eight_bit_adder_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/eight_bit_adder_reg.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_adder_reg
// Description : Registered unsigned adder built from a ripple-carry chain of
//               full-adder cells. The sum and carry-out are captured in an
//               output register, giving one clock of latency and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One full-adder cell of the ripple chain.
// ----------------------------------------------------------------------------
module eight_bit_adder_reg_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic w_prop;

  // Propagate term is shared by the sum and the carry.
  assign w_prop = a_i ^ b_i;
  assign s_o    = w_prop ^ c_i;
  assign c_o    = (a_i & b_i) | (c_i & w_prop);

endmodule

// ----------------------------------------------------------------------------
// Top level: ripple chain plus output register.
// ----------------------------------------------------------------------------
module eight_bit_adder_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             finalcarry,
  output logic             out_valid
);

  // Carry chain: w_carry[0] is the tied-off carry-in, w_carry[WIDTH] is the
  // carry-out of the most significant cell.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic             valid_q;
  logic             valid_d;

  // No carry-in: the operation is a plain a + b.
  assign w_carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
      eight_bit_adder_reg_fa u_fa (
        .a_i (a[gi]),
        .b_i (b[gi]),
        .c_i (w_carry[gi]),
        .s_o (w_sum[gi]),
        .c_o (w_carry[gi+1])
      );
    end
  endgenerate

  // Next-state: load a new result on a valid cycle, otherwise hold the last one.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = w_sum;
      carry_d = w_carry[WIDTH];
    end
  end

  // Output register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum        = sum_q;
  assign finalcarry = carry_q;
  assign out_valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_eight_bit_adder_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_eight_bit_adder_reg
// Description : Scoreboard testbench for eight_bit_adder_reg. The driver
//               pushes the expected post-edge outputs for every cycle it
//               drives; a monitor pops and compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eight_bit_adder_reg;

  typedef struct {
    logic       valid;
    logic       carry;
    logic [7:0] sum;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] sum;
  logic       finalcarry;
  logic       out_valid;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   popped;

  // Reference state: the value the output register should currently hold.
  logic [8:0] model_val;

  eight_bit_adder_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .sum        (sum),
    .finalcarry (finalcarry),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the rising edge and record what the
  // outputs must be after that edge.
  task automatic step(input logic rn, input logic v, input logic [7:0] av,
                      input logic [7:0] bv);
    exp_t e;
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    a        = av;
    b        = bv;
    if (!rn) begin
      model_val = 9'd0;
      e.valid   = 1'b0;
    end else if (v) begin
      model_val = {1'b0, av} + {1'b0, bv};
      e.valid   = 1'b1;
    end else begin
      e.valid   = 1'b0;
    end
    e.carry = model_val[8];
    e.sum   = model_val[7:0];
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        popped++;
        checks++;
        if (out_valid !== e.valid || finalcarry !== e.carry || sum !== e.sum) begin
          errors++;
          $display("FAIL out#%0d: got valid=%b carry=%b sum=%02h expected valid=%b carry=%b sum=%02h",
                   popped, out_valid, finalcarry, sum, e.valid, e.carry, e.sum);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    popped    = 0;
    model_val = 9'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;

    // Reset held with a live operation present.
    step(1'b0, 1'b1, 8'hFF, 8'h01);
    step(1'b0, 1'b1, 8'hFF, 8'h01);

    // Boundary values.
    step(1'b1, 1'b1, 8'hFF, 8'h01);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'h80, 8'h80);
    step(1'b1, 1'b1, 8'h7F, 8'h00);

    // Hold with toggling operands.
    step(1'b1, 1'b1, 8'h12, 8'h34);
    step(1'b1, 1'b0, 8'hAA, 8'h55);
    step(1'b1, 1'b0, 8'h55, 8'hAA);
    step(1'b1, 1'b0, 8'hFF, 8'hFF);

    // Back-to-back.
    step(1'b1, 1'b1, 8'h01, 8'h01);
    step(1'b1, 1'b1, 8'hF0, 8'h20);
    step(1'b1, 1'b1, 8'h00, 8'h00);

    // Reset mid-stream, then resume.
    step(1'b1, 1'b1, 8'hC3, 8'h5A);
    step(1'b0, 1'b1, 8'hEE, 8'h33);
    step(1'b1, 1'b1, 8'h40, 8'hC0);
    step(1'b1, 1'b1, 8'h11, 8'h22);

    // Randomised mix of resets, bubbles and operations.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(31) != 0), ($urandom_range(3) != 0),
           8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    // Exhaustive sweep, back-to-back.
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        step(1'b1, 1'b1, 8'(ia), 8'(ib));
      end
    end

    step(1'b1, 1'b0, 8'h00, 8'h00);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
